// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared frame-buffer geometry, FSM state type and a pixel
//                address helper for the rectangle-fill engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row-major frame-buffer address, truncated to the write-port width.
  function automatic logic [ADDR_W-1:0] pixel_addr(input int unsigned row,
                                                   input int unsigned col);
    int unsigned lin;
    lin = row * COLS + col;
    return lin[ADDR_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fill_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fill_addr_gen
//  Description : Column/row counters and row-base accumulator for a rectangle
//                fill. The addr output is the address of the pixel that the
//                counters will describe after the current edge, so the caller
//                can register it into the write port in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_addr_gen
  import video_pkg::*;
#(
  parameter int COLS   = video_pkg::COLS,
  parameter int ADDR_W = video_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [6:0]        x,
  input  logic [5:0]        y,
  input  logic [6:0]        w,
  input  logic [5:0]        h,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [6:0]        x_q, w_q, col_cnt, col_nxt, x_nxt;
  logic [5:0]        h_q, row_cnt, row_nxt;
  logic [ADDR_W-1:0] row_base, base_nxt;
  logic              end_of_row;

  assign end_of_row = (col_cnt == w_q - 7'd1);
  assign last       = end_of_row && (row_cnt == h_q - 6'd1);

  // Next counter values: the only multiply happens on start, rows then add COLS.
  always_comb begin
    col_nxt  = col_cnt;
    row_nxt  = row_cnt;
    base_nxt = row_base;
    x_nxt    = x_q;
    if (start) begin
      col_nxt  = 7'd0;
      row_nxt  = 6'd0;
      base_nxt = ADDR_W'(y) * ADDR_W'(COLS);
      x_nxt    = x;
    end else if (step) begin
      if (end_of_row) begin
        col_nxt  = 7'd0;
        row_nxt  = row_cnt + 6'd1;
        base_nxt = row_base + ADDR_W'(COLS);
      end else begin
        col_nxt  = col_cnt + 7'd1;
      end
    end
    addr = base_nxt + ADDR_W'(x_nxt) + ADDR_W'(col_nxt);
  end

  // Counter and geometry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      row_base <= '0;
    end else begin
      if (start) begin
        w_q <= w;
        h_q <= h;
      end
      x_q      <= x_nxt;
      col_cnt  <= col_nxt;
      row_cnt  <= row_nxt;
      row_base <= base_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rect_fill_engine
//  Description : Accepts one rectangle-fill command over valid/ready and emits
//                one registered frame-buffer write per clock until the block
//                is painted, then pulses done.
//                Build option RECT_FILL_CLIP_EN: clip the rectangle to the
//                screen at accept time; otherwise rows overrun linearly and
//                addresses wrap modulo 2^ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_fill_engine
  import video_pkg::*;
#(
  parameter int COLS   = video_pkg::COLS,
  parameter int ADDR_W = video_pkg::ADDR_W,
  parameter int DATA_W = video_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_x,
  input  logic [5:0]        cmd_y,
  input  logic [6:0]        cmd_w,
  input  logic [5:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_web,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [6:0]        w_eff;
  logic [5:0]        h_eff;
  logic              area_zero, start, step, web_nxt, last;
  logic [ADDR_W-1:0] gen_addr;

`ifdef RECT_FILL_CLIP_EN
  logic [7:0] x8, y8, room_x, room_y;

  // Clip width/height to the visible area; off-screen origins give zero area.
  always_comb begin
    x8     = {1'b0, cmd_x};
    y8     = {2'b00, cmd_y};
    room_x = 8'(COLS) - x8;
    room_y = 8'(video_pkg::ROWS) - y8;
    w_eff  = 7'd0;
    h_eff  = 6'd0;
    if (x8 < 8'(COLS)) begin
      w_eff = ({1'b0, cmd_w} < room_x) ? cmd_w : room_x[6:0];
    end
    if (y8 < 8'(video_pkg::ROWS)) begin
      h_eff = ({2'b00, cmd_h} < room_y) ? cmd_h : room_y[5:0];
    end
  end
`else
  assign w_eff = cmd_w;
  assign h_eff = cmd_h;
`endif

  assign area_zero = (w_eff == 7'd0) || (h_eff == 6'd0);
  assign cmd_ready = (state == IDLE);
  assign start     = cmd_ready && cmd_valid;
  assign step      = (state == FILL) && !last;

  fill_addr_gen #(
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .step  (step),
    .x     (cmd_x),
    .y     (cmd_y),
    .w     (w_eff),
    .h     (h_eff),
    .addr  (gen_addr),
    .last  (last)
  );

  // Next state and next write-enable.
  always_comb begin
    state_nxt = state;
    web_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = area_zero ? DONE : FILL;
          web_nxt   = !area_zero;
        end
      end
      FILL: begin
        if (last) begin
          state_nxt = DONE;
        end else begin
          web_nxt = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered write-port / status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_web   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_web <= web_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      if (web_nxt) begin
        mem_waddr <= gen_addr;
      end
      if (start) begin
        mem_wdata <= cmd_color;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_fill_engine
//  Description : Self-checking bench for rect_fill_engine; expected write
//                sequences come from a per-pixel rectangle model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_fill_engine;
  import video_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [6:0]        cmd_x;
  logic [5:0]        cmd_y;
  logic [6:0]        cmd_w;
  logic [5:0]        cmd_h;
  logic [DATA_W-1:0] cmd_color;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_web;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_q[$];

  rect_fill_engine dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_web   (mem_web),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: the list of addresses painted for a command, in row-major order.
  task automatic build(input int x, input int y, input int w, input int h);
    int we, he;
    exp_q.delete();
`ifdef RECT_FILL_CLIP_EN
    we = (x >= COLS) ? 0 : ((w < COLS - x) ? w : COLS - x);
    he = (y >= ROWS) ? 0 : ((h < ROWS - y) ? h : ROWS - y);
`else
    we = w;
    he = h;
`endif
    for (int r = 0; r < he; r++)
      for (int c = 0; c < we; c++)
        exp_q.push_back(pixel_addr(y + r, x + c));
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [DATA_W-1:0] color, input bit hold);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_x     = 7'(x);
    cmd_y     = 6'(y);
    cmd_w     = 7'(w);
    cmd_h     = 6'(h);
    cmd_color = color;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Checks every write cycle, the done cycle and the following idle cycle.
  task automatic expect_run(input logic [DATA_W-1:0] color);
    int n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("web[%0d]", k), 32'(mem_web), 32'd1);
      check($sformatf("addr[%0d]", k), 32'(mem_waddr), 32'(exp_q[k]));
      check($sformatf("data[%0d]", k), 32'(mem_wdata), 32'(color));
      check($sformatf("done_early[%0d]", k), 32'(done), 32'd0);
      check($sformatf("busy_fill[%0d]", k), 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("web_end", 32'(mem_web), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("ready_in_done", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_web", 32'(mem_web), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_first", 32'(cmd_ready), 32'd1);
    check("web_first", 32'(mem_web), 32'd0);

    // Basic 3x2 fill
    build(2, 3, 3, 2);
    issue(2, 3, 3, 2, 24'h00ff00, 1'b0);
    expect_run(24'h00ff00);

    // Empty command
    build(0, 0, 0, 5);
    issue(0, 0, 0, 5, 24'h123456, 1'b0);
    expect_run(24'h123456);

    // Bottom-right corner overrun
    build(78, 59, 5, 4);
    issue(78, 59, 5, 4, 24'habcdef, 1'b0);
    expect_run(24'habcdef);

    // New command held on valid during a fill is taken only after done
    build(10, 10, 4, 3);
    issue(10, 10, 4, 3, 24'h111111, 1'b1);
    cmd_x     = 7'd5;
    cmd_y     = 6'd20;
    cmd_w     = 7'd3;
    cmd_h     = 6'd2;
    cmd_color = 24'h222222;
    expect_run(24'h111111);
    build(5, 20, 3, 2);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_run(24'h222222);

    // Reset in the middle of a 4x4 fill
    build(0, 1, 4, 4);
    issue(0, 1, 4, 4, 24'h0f0f0f, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pre_rst_addr[%0d]", k), 32'(mem_waddr), 32'(exp_q[k]));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_web", 32'(mem_web), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_done[%0d]", k), 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_done", 32'(done), 32'd0);
    build(7, 30, 2, 3);
    issue(7, 30, 2, 3, 24'h5a5a5a, 1'b0);
    expect_run(24'h5a5a5a);

    // Random commands against the model
    for (int i = 0; i < 25; i++) begin
      int x, y, w, h;
      logic [DATA_W-1:0] c;
      x = int'($urandom_range(0, 127));
      y = int'($urandom_range(0, 63));
      w = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 6));
      c = DATA_W'($urandom);
      build(x, y, w, h);
      issue(x, y, w, h, c, 1'b0);
      expect_run(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
